// File: rtl/com_uart_rx_sequencer.sv
// UART receive frame sequencer: start, LSB-first data, optional parity, stop; hands bytes to a 1-entry holding register.
// Latency: rx_valid and stop_cond rise 1 cycle after the final stop-bit sample tick (plus SYNC_STAGES on the inputs).
// Backpressure: a held, unconsumed word is kept; a newly committed word is dropped and overrun_err pulses.
module com_uart_rx_sequencer #(
  parameter int DATA_WIDTH        = 8,
  parameter int PARITY_EN         = 0,
  parameter int PARITY_ODD        = 0,
  parameter int STOP_BITS         = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int STOP_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                  normal_mode_clk,
  input  logic                  rst_n,
  input  logic                  rx_port,
  input  logic                  baudrate_clk,
  output logic                  stop_cond,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  // Counter widths and their terminal values, sized so comparisons stay width-matched.
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SPW = $clog2(STOP_PULSE_CYCLES + 2);

  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic [TOW-1:0] TO_LIMIT  = TOW'(TIMEOUT_CYCLES);
  localparam logic [SPW-1:0] PULSE_LEN = SPW'(STOP_PULSE_CYCLES);
  localparam logic           PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_END    = 3'd5
  } state_t;

  // Input synchronisers. The rx chain resets to the idle-line level so that
  // reset release never looks like a start-bit edge.
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic [SYNC_STAGES-1:0] baud_sync_q;
  logic                   rx_prev_q;
  logic                   baud_prev_q;
  logic                   rx_s;
  logic                   baud_s;
  logic                   rx_fall;
  logic                   tick;

  state_t                 state_q, state_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic                   perr_q, perr_d;
  logic [TOW-1:0]         to_cnt_q, to_cnt_d;
  logic [SPW-1:0]         sp_cnt_q, sp_cnt_d;
  logic                   stop_cond_q, stop_cond_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   active;
  logic                   timeout;
  logic                   commit;

  // Shift the asynchronous line and bit clock into the core clock domain.
  always_ff @(posedge normal_mode_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q   <= '1;
      baud_sync_q <= '0;
      rx_prev_q   <= 1'b1;
      baud_prev_q <= 1'b0;
    end else begin
      rx_sync_q   <= (rx_sync_q << 1) | SYNC_STAGES'(rx_port);
      baud_sync_q <= (baud_sync_q << 1) | SYNC_STAGES'(baudrate_clk);
      rx_prev_q   <= rx_s;
      baud_prev_q <= baud_s;
    end
  end

  assign rx_s    = rx_sync_q[SYNC_STAGES-1];
  assign baud_s  = baud_sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q & ~rx_s;
  // A falling edge of the bit clock marks the middle of a bit cell.
  assign tick    = baud_prev_q & ~baud_s;

  assign active  = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);
  // A tick arriving on the limit cycle still counts as progress.
  assign timeout = active && !tick && (to_cnt_q == TO_LIMIT);

  // Frame FSM, tick-gap watchdog, stop_cond pulse and holding-register update.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    perr_d        = perr_q;
    to_cnt_d      = to_cnt_q;
    sp_cnt_d      = sp_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    stop_cond_d   = 1'b0;
    commit        = 1'b0;

    // Watchdog counts idle cycles between ticks only while a frame is in flight.
    if (!active || tick) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
          end else begin
            // Line was back high at mid-start-bit: treat as a glitch.
            state_d     = S_END;
            frame_err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d   = {rx_s, shreg_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          perr_d    = (^shreg_q) ^ rx_s ^ PAR_ODD;
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == STOP_LAST) begin
            commit  = 1'b1;
            state_d = S_END;
          end
        end
      end
      S_END: begin
        // Hold here through a break so a low line cannot re-trigger START.
        if ((sp_cnt_q == PULSE_LEN) && rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_d     = S_END;
      frame_err_d = 1'b1;
    end

    // Pulse counter runs only inside END and is zero on entry.
    if (state_q == S_END) begin
      if (sp_cnt_q != PULSE_LEN) begin
        sp_cnt_d = sp_cnt_q + SPW'(1);
      end
    end else begin
      sp_cnt_d = '0;
    end
    stop_cond_d = (state_d == S_END) && (sp_cnt_d != PULSE_LEN);

    // Consumer handshake frees the slot; a same-cycle commit refills it.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = perr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge normal_mode_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      perr_q        <= 1'b0;
      to_cnt_q      <= '0;
      sp_cnt_q      <= '0;
      stop_cond_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      perr_q        <= perr_d;
      to_cnt_q      <= to_cnt_d;
      sp_cnt_q      <= sp_cnt_d;
      stop_cond_q   <= stop_cond_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign stop_cond   = stop_cond_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule
